// File: rtl/ram_bus_master_if.sv
// Host-side handshake bundle for ram_bus_master:
// request channel, write-data pull channel and read-data return.
interface ram_bus_master_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int LWIDTH = 4
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [LWIDTH-1:0] req_len;

  logic [DWIDTH-1:0] wdata;
  logic              wvalid;
  logic              wready;

  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              done;
  logic              busy;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_len,
    output wdata,
    output wvalid,
    input  req_ready,
    input  wready,
    input  rdata,
    input  rvalid,
    input  done,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_len,
    input  wdata,
    input  wvalid,
    output req_ready,
    output wready,
    output rdata,
    output rvalid,
    output done,
    output busy
  );

endinterface

// File: rtl/ram_bus_master.sv
// Bus initiator for the single-port RAM on the shared tri-state Data bus.
// Sequences host single/burst requests with a guaranteed idle turnaround.
module ram_bus_master #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int LWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  ram_bus_master_if.slave   host,
  inout  wire  [DWIDTH-1:0] Data,
  output logic [AWIDTH-1:0] Addr,
  output logic              rdEn,
  output logic              wrEn
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DRAIN
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] cur;
  logic [LWIDTH-1:0] cnt;
  logic              drive_en;
  logic [DWIDTH-1:0] drive_data;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              done;

  // The bus is only driven from registers, so Z is glitch-free.
  assign Data = drive_en ? drive_data : {DWIDTH{1'bz}};

  assign host.req_ready = (state == IDLE);
  assign host.wready    = (state == WR);
  assign host.busy      = (state != IDLE);
  assign host.rdata     = rdata;
  assign host.rvalid    = rvalid;
  assign host.done      = done;

  // Request sequencing, beat counting and registered bus drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= '0;
      Addr       <= '0;
      rdEn       <= 1'b0;
      wrEn       <= 1'b0;
      drive_en   <= 1'b0;
      drive_data <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      done       <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host.req_valid) begin
            cur <= host.req_addr;
            cnt <= host.req_len;
            if (host.req_we) begin
              state <= WR;
            end else begin
              Addr  <= host.req_addr;
              rdEn  <= 1'b1;
              state <= RD;
            end
          end
        end
        RD: begin
          rdata  <= Data;
          rvalid <= 1'b1;
          if (cnt == '0) begin
            rdEn  <= 1'b0;
            state <= DRAIN;
          end else begin
            Addr <= Addr + AWIDTH'(1);
            cnt  <= cnt - LWIDTH'(1);
          end
        end
        WR: begin
          if (host.wvalid) begin
            Addr       <= cur;
            drive_data <= host.wdata;
            wrEn       <= 1'b1;
            drive_en   <= 1'b1;
            cur        <= cur + AWIDTH'(1);
            if (cnt == '0) begin
              state <= DRAIN;
            end else begin
              cnt <= cnt - LWIDTH'(1);
            end
          end else begin
            wrEn     <= 1'b0;
            drive_en <= 1'b0;
          end
        end
        DRAIN: begin
          wrEn     <= 1'b0;
          rdEn     <= 1'b0;
          drive_en <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
Bus initiator for the single-port 32-bit RAM on the shared tri-state Data bus. It drives Addr/rdEn/wrEn and owns Data during writes. A host (CPU load/store unit) issues single or burst requests, and the block sequences them onto the bus. Read data is returned on a valid strobe, write data is pulled through a valid/ready handshake, and one idle bus cycle is guaranteed between transactions to prevent bus contention.

Parameters:
DWIDTH, 32, data bus width
AWIDTH, 8, RAM address width (256 words)
LWIDTH, 4, burst length field width; beats = req_len+1 (1..16)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  host request strobe
req_ready  output  1  high when a request can be accepted (state IDLE)
req_we  input  1  1 = write burst, 0 = read burst
req_addr  input  AWIDTH  start word address
req_len  input  LWIDTH  beats minus one
wdata  input  DWIDTH  host write data
wvalid  input  1  wdata valid
wready  output  1  block accepts wdata this cycle
rdata  output  DWIDTH  read data, registered
rvalid  output  1  rdata valid, one cycle per beat
done  output  1  one-cycle pulse when a burst completes
busy  output  1  high in any state other than IDLE
Data  inout  DWIDTH  shared RAM data bus
Addr  output  AWIDTH  RAM address
rdEn  output  1  RAM read enable, active high
wrEn  output  1  RAM write enable, active high

Behaviour:
- RAM contract: read is combinational (Data = storage[Addr] while rdEn & ~wrEn). Write is captured on the rising clk edge while wrEn is high.
- All bus outputs are registered: Addr, rdEn, wrEn, the Data drive value and the Data drive enable. Data = drive_en ? drive_data : 'z.
- Reset (reset low, asynchronous):
  - State = IDLE.
  - Addr=0, rdEn=0, wrEn=0, drive_en=0, so Data is high-Z immediately.
  - rdata=0, rvalid=0, done=0, beat counter=0.
  - Any burst in progress is abandoned with no done pulse.
- FSM states: IDLE, RD, WR, DRAIN.
  - req_ready = (state==IDLE).
  - wready = (state==WR).
  - busy = (state!=IDLE).
- IDLE, on an edge with req_valid:
  - Latch the start address; beat counter <= req_len.
  - If req_we=0: Addr<=req_addr, rdEn<=1, go to RD.
  - If req_we=1: go to WR; the bus stays idle.
  - req_valid outside IDLE is ignored and never queued.
- RD, at each edge:
  - rdata<=Data; rvalid<=1 for the following cycle.
  - If counter==0: rdEn<=0, go to DRAIN.
  - Otherwise: Addr<=Addr+1, counter--.
  - One beat per cycle. Beat i is valid in cycle E0+i+1, where E0 is the accept edge.
  - No read backpressure; the host must take every rvalid.
- WR, at an edge with wvalid:
  - Addr<=current address, drive_data<=wdata, wrEn<=1, drive_en<=1; current address++.
  - The RAM writes at the next edge.
  - If counter==0: go to DRAIN; otherwise counter--.
  - At a WR edge without wvalid: wrEn<=0, drive_en<=0 (a bubble, nothing written).
- DRAIN:
  - The last write (if any) completes on the bus during this cycle.
  - At the edge: wrEn<=0, rdEn<=0, drive_en<=0, done<=1, go to IDLE.
  - done lasts exactly one cycle: the first IDLE cycle.
  - A new request may be accepted in that same cycle.
- Turnaround guarantee: at least one cycle with rdEn=wrEn=0 and Data high-Z before any new bus access.
- Address arithmetic: modulo 2^AWIDTH; 0xFF+1 = 0x00, silent wrap.
- Invariants, all cycles:
  - rdEn & wrEn never both 1.
  - drive_en implies wrEn.
  - rdEn implies drive_en=0.
- rvalid is cleared on any edge with no read capture.

Test Plan:
1. Write req_addr=0x10, req_len=0, wdata=0xDEADBEEF with wvalid held -> exactly one wrEn cycle with Addr=0x10 and Data=0xDEADBEEF, done one cycle later. Then read 0x10 -> rvalid with rdata=0xDEADBEEF, done after.
2. Burst write 4 beats at 0xFE (values 1,2,3,4), then burst read len=3 at 0xFE -> Addr sequence FE,FF,00,01. rvalid on 4 consecutive cycles with rdata 1,2,3,4.
3. Burst write len=2 with wvalid low for 2 cycles between beats -> wrEn and drive_en low during the gaps. Only 3 RAM writes, to consecutive addresses; done after the third.
4. Write burst immediately followed by a read request at the done cycle -> at least one cycle with Data=Z and rdEn=wrEn=0 between them. No cycle with rdEn and wrEn both high.
5. Assert reset low mid-burst (after 2 of 8 read beats) -> Data Z and rdEn/wrEn/rvalid 0 asynchronously, no done. After release, req_ready=1 and a new single read works.
6. Pulse req_valid while busy -> ignored. Only the original burst runs, with exactly one done.
